// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch front end for a single-ported synchronous instruction RAM
// with one-cycle read latency. It issues sequential word reads and follows
// branch/jump redirects. Each returned word is presented downstream together
// with its byte address. While downstream stalls, a one-entry skid buffer
// catches the word that is already in flight, so stall release costs no
// bubble and never drops or duplicates a word.
//
// Parameters
//   RESET_PC          byte address of the first fetch after reset
//
// Ports
//   clk               clock, all state on the rising edge
//   resetn            asynchronous active-low reset
//   stall             downstream cannot accept the presented word this cycle
//   redirect_valid    redirect request this cycle
//   redirect_pc       redirect target byte address ([1:0] ignored)
//   instr_sram_en     RAM read enable
//   instr_sram_we     RAM write enable (always 0)
//   instr_sram_addr   RAM word address
//   instr_sram_wdata  RAM write data (always 0)
//   instr             RAM read data, valid the cycle after an enabled read
//   if_valid          presented word is valid
//   if_pc             byte address of the presented word
//   if_instr          presented instruction word
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_sram_en,
  output logic        instr_sram_we,
  output logic [31:0] instr_sram_addr,
  output logic [31:0] instr_sram_wdata,
  input  logic [31:0] instr,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic {
    HOLD  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  // A read issued last cycle whose data is on instr now.
  logic        inflight_reg, inflight_next;
  logic [31:0] inflight_pc_reg, inflight_pc_next;
  // Word captured while downstream was stalled.
  logic        skid_valid_reg, skid_valid_next;
  logic [31:0] skid_pc_reg, skid_pc_next;
  logic [31:0] skid_instr_reg, skid_instr_next;

  logic [31:0] issue_pc;

  assign instr_sram_we    = 1'b0;
  assign instr_sram_wdata = 32'h0000_0000;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg       <= HOLD;
      fetch_pc_reg    <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 32'h0000_0000;
      skid_valid_reg  <= 1'b0;
      skid_pc_reg     <= 32'h0000_0000;
      skid_instr_reg  <= 32'h0000_0000;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      skid_valid_reg  <= skid_valid_next;
      skid_pc_reg     <= skid_pc_next;
      skid_instr_reg  <= skid_instr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    // An in-flight response lives for exactly one cycle: it is presented,
    // captured into the skid buffer, or squashed.
    inflight_next    = 1'b0;
    inflight_pc_next = inflight_pc_reg;
    skid_valid_next  = skid_valid_reg;
    skid_pc_next     = skid_pc_reg;
    skid_instr_next  = skid_instr_reg;
    issue_pc         = fetch_pc_reg;
    instr_sram_en    = 1'b0;
    instr_sram_addr  = 32'h0000_0000;
    if_valid         = 1'b0;
    if_pc            = 32'h0000_0000;
    if_instr         = 32'h0000_0000;

    case (state_reg)
      HOLD: begin
        // Redirects are ignored here so the first fetch is always RESET_PC.
        state_next = FETCH;
      end

      FETCH: begin
        if (redirect_valid) begin
          // Squash everything older than the redirect and fetch the target
          // even under stall; if stall persists the target lands in the skid.
          issue_pc        = {redirect_pc[31:2], 2'b00};
          instr_sram_en   = 1'b1;
          skid_valid_next = 1'b0;
        end else begin
          if (skid_valid_reg) begin
            if_valid = 1'b1;
            if_pc    = skid_pc_reg;
            if_instr = skid_instr_reg;
          end else if (inflight_reg) begin
            if_valid = 1'b1;
            if_pc    = inflight_pc_reg;
            if_instr = instr;
          end

          if (stall) begin
            // Hold the presented word; park a fresh response so the RAM
            // output is free for the next read after release.
            if (inflight_reg && !skid_valid_reg) begin
              skid_valid_next = 1'b1;
              skid_pc_next    = inflight_pc_reg;
              skid_instr_next = instr;
            end
          end else begin
            // Presented word (if any) is accepted this cycle.
            instr_sram_en   = 1'b1;
            skid_valid_next = 1'b0;
          end
        end

        if (instr_sram_en) begin
          instr_sram_addr  = {2'b00, issue_pc[31:2]};
          inflight_next    = 1'b1;
          inflight_pc_next = issue_pc;
          fetch_pc_next    = issue_pc + 32'd4;
        end
      end

      default: begin
        state_next = HOLD;
      end
    endcase
  end

endmodule
